// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction encodings, opcodes and fetch FSM states.
// Imported by the fetch stage and by the decoder.
package fetch_stage_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_INSTR_W = 16;

    localparam logic [7:0]  DEF_RESET_PC  = 8'h00;
    localparam logic [15:0] DEF_HALT_WORD = 16'h0001;
    localparam logic [15:0] NOP_WORD      = 16'h0000;

    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_BLTZ = 4'b1011;

    typedef enum logic {
        RUN     = 1'b0,
        HALT_ST = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control from downstream, instruction RAM port and the IF/ID register outputs.
interface fetch_stage_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);
    logic               STALL;
    logic               REDIRECT;
    logic [ADDR_W-1:0]  REDIRECT_ADDR;
    logic [ADDR_W-1:0]  IMEM_ADDR;
    logic [INSTR_W-1:0] IMEM_Q;
    logic               IF_VALID;
    logic [INSTR_W-1:0] IF_INSTR;
    logic [ADDR_W-1:0]  IF_PC;
    logic [ADDR_W-1:0]  IF_PC_NEXT;
    logic               HALTED;

    modport master (
        input  STALL, REDIRECT, REDIRECT_ADDR, IMEM_Q,
        output IMEM_ADDR, IF_VALID, IF_INSTR, IF_PC, IF_PC_NEXT, HALTED
    );

    modport slave (
        output STALL, REDIRECT, REDIRECT_ADDR, IMEM_Q,
        input  IMEM_ADDR, IF_VALID, IF_INSTR, IF_PC, IF_PC_NEXT, HALTED
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with +2 incrementer, redirect mux and bit-0 masking.
module fetch_pc_reg #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              HOLD,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_ADDR,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_PLUS2
);

    localparam logic [ADDR_W-1:0] HALFWORD_MASK = ~ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q;

    assign PC       = pc_q;
    assign PC_PLUS2 = pc_q + ADDR_W'(2);

    // Redirect beats hold; instructions are half-word aligned so bit 0 is always cleared.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q <= RESET_PC & HALFWORD_MASK;
        end else if (REDIRECT) begin
            pc_q <= REDIRECT_ADDR & HALFWORD_MASK;
        end else if (!HOLD) begin
            pc_q <= PC_PLUS2;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction RAM address, fills the IF/ID register,
// and handles stall, branch redirect/flush and the HALT freeze.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        INSTR_W   = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(DEF_HALT_WORD)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    fetch_stage_if.master bus
);

    fetch_state_e       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus2;
    logic               is_halt_word;
    logic               pc_hold;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_next;
    logic               halted;

    assign is_halt_word = (bus.IMEM_Q == HALT_WORD);
    // PC freezes on the HALT word itself, so IMEM_ADDR keeps pointing at it while halted.
    assign pc_hold      = bus.STALL || (state == HALT_ST) || is_halt_word;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .HOLD          (pc_hold),
        .REDIRECT      (bus.REDIRECT),
        .REDIRECT_ADDR (bus.REDIRECT_ADDR),
        .PC            (pc),
        .PC_PLUS2      (pc_plus2)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= RUN;
            halted     <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_pc_next <= '0;
        end else if (bus.REDIRECT) begin
            state    <= RUN;
            halted   <= 1'b0;
            if_valid <= 1'b0;
        end else if (bus.STALL) begin
            state <= state;
        end else if (state == HALT_ST) begin
            if_valid <= 1'b0;
        end else begin
            if_instr   <= bus.IMEM_Q;
            if_pc      <= pc;
            if_pc_next <= pc_plus2;
            if_valid   <= 1'b1;
            if (is_halt_word) begin
                state  <= HALT_ST;
                halted <= 1'b1;
            end
        end
    end

    assign bus.IMEM_ADDR  = pc;
    assign bus.IF_VALID   = if_valid;
    assign bus.IF_INSTR   = if_instr;
    assign bus.IF_PC      = if_pc;
    assign bus.IF_PC_NEXT = if_pc_next;
    assign bus.HALTED     = halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural fetch model checked every cycle plus literal checkpoints.
module tb_fetch_stage;

    logic CLK = 1'b0;
    logic RESET_N = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    logic [15:0] mem [128];

    fetch_stage_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    fetch_stage #(
        .ADDR_W    (8),
        .INSTR_W   (16),
        .RESET_PC  (8'h00),
        .HALT_WORD (16'h0001)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.IMEM_Q = mem[bus.IMEM_ADDR[7:1]];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: what a fetch unit must present after each edge.
    logic [7:0]  m_pc     = 8'h00;
    logic        m_valid  = 1'b0;
    logic [15:0] m_instr  = 16'h0000;
    logic [7:0]  m_ifpc   = 8'h00;
    logic [7:0]  m_ifnext = 8'h00;
    logic        m_halted = 1'b0;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_pc <= 8'h00; m_valid <= 1'b0; m_instr <= 16'h0000;
            m_ifpc <= 8'h00; m_ifnext <= 8'h00; m_halted <= 1'b0;
        end else if (bus.REDIRECT) begin
            m_pc <= {bus.REDIRECT_ADDR[7:1], 1'b0};
            m_valid <= 1'b0;
            m_halted <= 1'b0;
        end else if (bus.STALL) begin
            m_pc <= m_pc;
        end else if (m_halted) begin
            m_valid <= 1'b0;
        end else begin
            m_instr  <= mem[m_pc[7:1]];
            m_ifpc   <= m_pc;
            m_ifnext <= 8'((int'(m_pc) + 2) % 256);
            m_valid  <= 1'b1;
            if (mem[m_pc[7:1]] == 16'h0001) m_halted <= 1'b1;
            else m_pc <= 8'((int'(m_pc) + 2) % 256);
        end
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            chk("model_imem_addr", {8'h00, bus.IMEM_ADDR}, {8'h00, m_pc});
            chk("model_if_valid", {15'h0, bus.IF_VALID}, {15'h0, m_valid});
            if (m_valid) begin
                chk("model_if_instr", bus.IF_INSTR, m_instr);
                chk("model_if_pc", {8'h00, bus.IF_PC}, {8'h00, m_ifpc});
                chk("model_if_pc_next", {8'h00, bus.IF_PC_NEXT}, {8'h00, m_ifnext});
            end
            chk("model_halted", {15'h0, bus.HALTED}, {15'h0, m_halted});
        end
    end

    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic chk_if(input string nm, input logic [7:0] addr, input logic v,
                          input logic [15:0] ins, input logic [7:0] ifpc, input logic h);
        chk({nm, "_addr"}, {8'h00, bus.IMEM_ADDR}, {8'h00, addr});
        chk({nm, "_valid"}, {15'h0, bus.IF_VALID}, {15'h0, v});
        chk({nm, "_instr"}, bus.IF_INSTR, ins);
        chk({nm, "_pc"}, {8'h00, bus.IF_PC}, {8'h00, ifpc});
        chk({nm, "_halted"}, {15'h0, bus.HALTED}, {15'h0, h});
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0] = 16'hF001; mem[1] = 16'h5002; mem[2] = 16'h6003;
        mem[8'h13] = 16'h1234; mem[8'h08] = 16'hA5A5; mem[127] = 16'hBEEF;
        bus.STALL = 1'b0; bus.REDIRECT = 1'b0; bus.REDIRECT_ADDR = 8'h00;

        #1 RESET_N = 1'b0;
        #1;
        chk_if("reset", 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("reset_pc_next", {8'h00, bus.IF_PC_NEXT}, 16'h0000);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Free-running fetch
        step(); chk_if("run1", 8'h02, 1'b1, 16'hF001, 8'h00, 1'b0);
        chk("run1_pc_next", {8'h00, bus.IF_PC_NEXT}, 16'h0002);
        step(); chk_if("run2", 8'h04, 1'b1, 16'h5002, 8'h02, 1'b0);

        // Stall two cycles at PC=04
        bus.STALL = 1'b1;
        step(); chk_if("stall1", 8'h04, 1'b1, 16'h5002, 8'h02, 1'b0);
        step(); chk_if("stall2", 8'h04, 1'b1, 16'h5002, 8'h02, 1'b0);
        bus.STALL = 1'b0;
        step(); chk_if("resume", 8'h06, 1'b1, 16'h6003, 8'h04, 1'b0);
        step(); step(); chk("pc_0a", {8'h00, bus.IMEM_ADDR}, 16'h000A);

        // Redirect to odd target 27 while PC=0A
        bus.REDIRECT = 1'b1; bus.REDIRECT_ADDR = 8'h27;
        step(); chk("redir_valid", {15'h0, bus.IF_VALID}, 16'h0000);
        chk("redir_addr", {8'h00, bus.IMEM_ADDR}, 16'h0026);
        bus.REDIRECT = 1'b0;
        step(); chk_if("redir_tgt", 8'h28, 1'b1, 16'h1234, 8'h26, 1'b0);

        // Redirect together with stall
        bus.STALL = 1'b1; bus.REDIRECT = 1'b1; bus.REDIRECT_ADDR = 8'h41;
        step(); chk("rs_valid", {15'h0, bus.IF_VALID}, 16'h0000);
        chk("rs_addr", {8'h00, bus.IMEM_ADDR}, 16'h0040);
        bus.REDIRECT = 1'b0;
        step(); chk("rs_hold", {8'h00, bus.IMEM_ADDR}, 16'h0040);
        bus.STALL = 1'b0;

        // HALT at PC=02
        mem[1] = 16'h0001;
        bus.REDIRECT = 1'b1; bus.REDIRECT_ADDR = 8'h00;
        step(); bus.REDIRECT = 1'b0;
        step(); chk_if("pre_halt", 8'h02, 1'b1, 16'hF001, 8'h00, 1'b0);
        step(); chk_if("halt_word", 8'h02, 1'b1, 16'h0001, 8'h02, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_valid", {15'h0, bus.IF_VALID}, 16'h0000);
            chk("halt_addr", {8'h00, bus.IMEM_ADDR}, 16'h0002);
            chk("halt_flag", {15'h0, bus.HALTED}, 16'h0001);
        end
        bus.REDIRECT = 1'b1; bus.REDIRECT_ADDR = 8'h10;
        step(); chk("unhalt_flag", {15'h0, bus.HALTED}, 16'h0000);
        chk("unhalt_addr", {8'h00, bus.IMEM_ADDR}, 16'h0010);
        bus.REDIRECT = 1'b0;
        step(); chk_if("after_halt", 8'h12, 1'b1, 16'hA5A5, 8'h10, 1'b0);

        // Wrap from FE to 00
        bus.REDIRECT = 1'b1; bus.REDIRECT_ADDR = 8'hFE;
        step(); chk("wrap_addr_fe", {8'h00, bus.IMEM_ADDR}, 16'h00FE);
        bus.REDIRECT = 1'b0;
        step(); chk_if("wrap", 8'h00, 1'b1, 16'hBEEF, 8'hFE, 1'b0);
        chk("wrap_pc_next", {8'h00, bus.IF_PC_NEXT}, 16'h0000);
        step(); chk_if("post_wrap", 8'h02, 1'b1, 16'hF001, 8'h00, 1'b0);

        // Asynchronous reset between edges
        RESET_N = 1'b0;
        #1;
        chk_if("areset", 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0);
        chk("areset_pc_next", {8'h00, bus.IF_PC_NEXT}, 16'h0000);
        #1 RESET_N = 1'b1;
        step(); chk_if("restart", 8'h02, 1'b1, 16'hF001, 8'h00, 1'b0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
